// File: rtl/bnn_pkg.sv
// bnn_pkg: shared FSM state type and width helpers for the BNN PE array
package bnn_pkg;
  typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_t;
  function automatic int pcw_f(input int ws);
    return $clog2(ws + 1);
  endfunction
  function automatic int accw_f(input int mb, input int ws);
    return $clog2(mb * ws + 1);
  endfunction
  function automatic int bcw_f(input int mb);
    return $clog2(mb + 1);
  endfunction
endpackage

// File: rtl/bnn_popcount_pe.sv
// bnn_popcount_pe: combinational masked XNOR-popcount of one PE word
module bnn_popcount_pe #(
  parameter int WORD_SIZE = 64,
  parameter int PCW = 7
) (
  input  logic [WORD_SIZE-1:0] i_w,
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_m,
  output logic [PCW-1:0]       o_pc
);
  logic [WORD_SIZE-1:0] w_hit;
  assign w_hit = ~(i_w ^ i_a) & i_m;
  always_comb begin
    o_pc = '0;
    for (int k = 0; k < WORD_SIZE; k++) o_pc = o_pc + PCW'(w_hit[k]);
  end
endmodule

// File: rtl/bnn_pe_array_acc.sv
// bnn_pe_array_acc: multi-beat XNOR-popcount accumulating PE array with thresholded output
module bnn_pe_array_acc import bnn_pkg::*; #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int WORD_SIZE = 64,
  parameter int MAX_BEATS = 16,
  parameter int PIPELINE = 1,
  localparam int NUM_PES = ROWS * COLS,
  localparam int PCW = pcw_f(WORD_SIZE),
  localparam int ACC_W = accw_f(MAX_BEATS, WORD_SIZE),
  localparam int BCW = bcw_f(MAX_BEATS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [NUM_PES*WORD_SIZE-1:0] weights_in_flat,
  input  logic [NUM_PES*WORD_SIZE-1:0] activations_in_flat,
  input  logic [NUM_PES*WORD_SIZE-1:0] valid_mask_flat,
  input  logic [NUM_PES*ACC_W-1:0]     thresh_flat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_PES*ACC_W-1:0]     acc_out_flat,
  output logic [NUM_PES-1:0]           bin_out,
  output logic [BCW-1:0]               beats_out,
  output logic                         err_overflow
);
  state_t r_state;
  logic [BCW-1:0] r_cnt, r_pbeats, r_beats_out, w_sbeats;
  logic r_pv, r_pfirst, r_pterm, r_err;
  logic w_acc, w_term, w_sv, w_sfirst, w_sterm;
  assign in_ready = r_state == ACCUM;
  assign out_valid = r_state == HOLD;
  assign beats_out = r_beats_out;
  assign err_overflow = r_err;
  assign w_acc = in_valid & in_ready;
  assign w_term = in_last | (r_cnt == BCW'(MAX_BEATS - 1));
  // accumulate-stage view: the registered beat when pipelined, else the live beat
  assign w_sv = PIPELINE != 0 ? r_pv : w_acc;
  assign w_sfirst = PIPELINE != 0 ? r_pfirst : r_cnt == '0;
  assign w_sterm = PIPELINE != 0 ? r_pterm : w_term;
  assign w_sbeats = PIPELINE != 0 ? r_pbeats : r_cnt + BCW'(1);
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= ACCUM;
      r_cnt <= '0;
      r_pv <= 1'b0;
      r_pfirst <= 1'b0;
      r_pterm <= 1'b0;
      r_pbeats <= '0;
      r_beats_out <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= (r_state == ACCUM && w_acc && w_term) ? (PIPELINE != 0 ? FLUSH : HOLD) :
                 r_state == FLUSH ? HOLD :
                 (r_state == HOLD && out_ready) ? ACCUM : r_state;
      r_cnt <= w_acc ? (w_term ? '0 : r_cnt + BCW'(1)) : r_cnt;
      r_pv <= w_acc;
      r_pfirst <= r_cnt == '0;
      r_pterm <= w_term;
      r_pbeats <= r_cnt + BCW'(1);
      r_err <= r_err | (w_acc & w_term & ~in_last);
      if (w_sv & w_sterm) r_beats_out <= w_sbeats;
    end
  for (genvar i = 0; i < NUM_PES; i++) begin : g_pe
    logic [PCW-1:0] w_pc, r_ppc, w_spc;
    logic [ACC_W-1:0] r_acc, r_out, w_sum;
    logic r_bin;
    bnn_popcount_pe #(.WORD_SIZE(WORD_SIZE), .PCW(PCW)) u_pc (
      .i_w(weights_in_flat[i*WORD_SIZE +: WORD_SIZE]),
      .i_a(activations_in_flat[i*WORD_SIZE +: WORD_SIZE]),
      .i_m(valid_mask_flat[i*WORD_SIZE +: WORD_SIZE]),
      .o_pc(w_pc)
    );
    assign w_spc = PIPELINE != 0 ? r_ppc : w_pc;
    assign w_sum = (w_sfirst ? '0 : r_acc) + ACC_W'(w_spc);
    always_ff @(posedge clk)
      if (rst) begin
        r_ppc <= '0;
        r_acc <= '0;
        r_out <= '0;
        r_bin <= 1'b0;
      end else begin
        if (w_acc) r_ppc <= w_pc;
        if (w_sv) r_acc <= w_sum;
        if (w_sv & w_sterm) begin
          r_out <= w_sum;
          r_bin <= w_sum >= thresh_flat[i*ACC_W +: ACC_W];
        end
      end
    assign acc_out_flat[i*ACC_W +: ACC_W] = r_out;
    assign bin_out[i] = r_bin;
  end
endmodule

// File: tb/tb_bnn_pe_array_acc.sv
// tb_bnn_pe_array_acc: table-driven and scoreboard checks of the accumulating PE array
module tb_bnn_pe_array_acc;
  localparam int NP = 64, WS = 64, AW = 11, BW = 5, MB = 16;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, err_overflow;
  logic [NP*WS-1:0] w_f, a_f, m_f;
  logic [NP*AW-1:0] th_f, acc_f, exp192;
  logic [NP-1:0] bin;
  logic [BW-1:0] beats;
  logic p_in_valid = 1'b0, p_in_last = 1'b0, p_out_ready = 1'b1;
  logic p_in_ready, p_out_valid, p_err;
  logic [127:0] p_w, p_a, p_m;
  logic [17:0] p_th, p_acc;
  logic [1:0] p_bin;
  logic [2:0] p_beats;
  bnn_pe_array_acc #(.ROWS(8), .COLS(8), .WORD_SIZE(64), .MAX_BEATS(16), .PIPELINE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .weights_in_flat(w_f), .activations_in_flat(a_f), .valid_mask_flat(m_f), .thresh_flat(th_f),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out_flat(acc_f), .bin_out(bin),
    .beats_out(beats), .err_overflow(err_overflow)
  );
  bnn_pe_array_acc #(.ROWS(1), .COLS(2), .WORD_SIZE(64), .MAX_BEATS(4), .PIPELINE(0)) dut_p0 (
    .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready), .in_last(p_in_last),
    .weights_in_flat(p_w), .activations_in_flat(p_a), .valid_mask_flat(p_m), .thresh_flat(p_th),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .acc_out_flat(p_acc), .bin_out(p_bin),
    .beats_out(p_beats), .err_overflow(p_err)
  );
  typedef struct packed {
    logic [NP*AW-1:0] acc;
    logic [NP-1:0] bin;
    logic [BW-1:0] beats;
  } exp_t;
  typedef struct {
    logic [63:0] w, a, m;
    int nb, th, acc;
    logic bin;
    int nbeat;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[6];
  int n_chk = 0, n_fail = 0;
  int m_acc[NP];
  int m_beats = 0;
  logic m_err = 1'b0;
  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic set_all(input logic [63:0] w, input logic [63:0] a, input logic [63:0] m, input int th);
    for (int i = 0; i < NP; i++) begin
      w_f[i*WS +: WS] = w;
      a_f[i*WS +: WS] = a;
      m_f[i*WS +: WS] = m;
      th_f[i*AW +: AW] = AW'(th);
    end
  endtask
  // model: accumulate per PE on each accepted beat, push the expected result on the terminal beat
  task automatic send_beat(input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_last = last;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) chk("accept_timeout", t, 0);
    m_beats++;
    for (int i = 0; i < NP; i++) begin
      int pc = $countones(~(w_f[i*WS +: WS] ^ a_f[i*WS +: WS]) & m_f[i*WS +: WS]);
      m_acc[i] = (m_beats == 1) ? pc : m_acc[i] + pc;
    end
    if (last || m_beats == MB) begin
      exp_t e;
      for (int i = 0; i < NP; i++) begin
        e.acc[i*AW +: AW] = AW'(m_acc[i]);
        e.bin[i] = m_acc[i] >= int'(th_f[i*AW +: AW]);
      end
      e.beats = BW'(m_beats);
      sb.push_back(e);
      if (!last) m_err = 1'b1;
      m_beats = 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic wait_out();
    int t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("out_timeout", t, 0);
  endtask
  task automatic p_beat(input logic last);
    int t = 0;
    p_in_valid = 1'b1;
    p_in_last = last;
    while (!p_in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("p_accept_timeout", t, 0);
    @(posedge clk); #1;
    p_in_valid = 1'b0;
    p_in_last = 1'b0;
  endtask
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("sb_acc", acc_f, e.acc);
        chk("sb_bin", bin, e.bin);
        chk("sb_beats", beats, e.beats);
        chk("sb_err", err_overflow, m_err);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, 192, 192, 1'b1, 3};
    tbl[1] = '{64'h0, 64'h0, 64'h0000_0000_FFFF_FFFF, 2, 64, 64, 1'b1, 2};
    tbl[2] = '{64'h0, 64'h0, 64'h0000_0000_FFFF_FFFF, 2, 65, 64, 1'b0, 2};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 1'b1, 1};
    tbl[4] = '{64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hFFFF_FFFF_FFFF_FFFF, 4, 200, 128, 1'b0, 4};
    tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16, 1024, 1024, 1'b1, 16};
    for (int i = 0; i < NP; i++) exp192[i*AW +: AW] = AW'(192);
    set_all(64'h0, 64'h0, 64'h0, 0);
    p_w = '1; p_a = '1; p_m = '1;
    p_th = {9'd100, 9'd200};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_acc", acc_f, 0);
    chk("rst_bin", bin, 0);
    chk("rst_beats", beats, 0);
    chk("rst_err", err_overflow, 0);
    // single beat, pipelined latency of two cycles
    set_all(64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 32);
    w_f[0 +: WS] = 64'h589A86C459345B3C;
    a_f[0 +: WS] = 64'h6FA49326961A604D;
    w_f[63*WS +: WS] = '1;
    a_f[63*WS +: WS] = '0;
    send_beat(1'b1);
    chk("t1_valid_t1", out_valid, 0);
    chk("t1_flush_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("t1_valid_t2", out_valid, 1);
    chk("t1_acc0", acc_f[0 +: AW], 28);
    chk("t1_acc1", acc_f[AW +: AW], 64);
    chk("t1_acc63", acc_f[63*AW +: AW], 0);
    chk("t1_bin", {bin[63], bin[1], bin[0]}, 3'b010);
    chk("t1_beats", beats, 1);
    @(posedge clk); #1;
    for (int v = 0; v < 6; v++) begin
      set_all(tbl[v].w, tbl[v].a, tbl[v].m, tbl[v].th);
      for (int b = 0; b < tbl[v].nb; b++) send_beat(b == tbl[v].nb - 1);
      wait_out();
      chk("tbl_acc0", acc_f[0 +: AW], tbl[v].acc);
      chk("tbl_acc63", acc_f[63*AW +: AW], tbl[v].acc);
      chk("tbl_bin0", bin[0], tbl[v].bin);
      chk("tbl_beats", beats, tbl[v].nbeat);
      chk("tbl_err", err_overflow, 0);
      @(posedge clk); #1;
    end
    // output stall with a beat waiting upstream
    set_all('1, '1, '1, 100);
    for (int b = 0; b < 3; b++) send_beat(b == 2);
    out_ready = 1'b0;
    wait_out();
    set_all(64'h0, 64'h0, 64'h0000_0000_FFFF_FFFF, 100);
    in_valid = 1'b1;
    in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_acc", acc_f, exp192);
      chk("stall_beats", beats, 3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_valid", out_valid, 0);
    send_beat(1'b1);
    wait_out();
    chk("fresh_acc0", acc_f[0 +: AW], 32);
    chk("fresh_beats", beats, 1);
    @(posedge clk); #1;
    // reset mid-vector discards the partial accumulation
    set_all('1, '1, '1, 0);
    send_beat(1'b0);
    send_beat(1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_beats = 0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_acc", acc_f, 0);
    chk("mrst_bin", bin, 0);
    chk("mrst_beats", beats, 0);
    send_beat(1'b1);
    wait_out();
    chk("mrst_new_acc", acc_f[0 +: AW], 64);
    chk("mrst_new_beats", beats, 1);
    @(posedge clk); #1;
    // forced termination at MAX_BEATS without in_last
    set_all('1, '1, '1, 1024);
    for (int b = 0; b < MB; b++) send_beat(1'b0);
    wait_out();
    chk("force_acc", acc_f[0 +: AW], 1024);
    chk("force_beats", beats, 16);
    chk("force_err", err_overflow, 1);
    @(posedge clk); #1;
    send_beat(1'b1);
    wait_out();
    chk("force_err_sticky", err_overflow, 1);
    chk("after_force_beats", beats, 1);
    @(posedge clk); #1;
    chk("sb_drained", sb.size(), 0);
    // unpipelined, MAX_BEATS=4 instance
    for (int b = 0; b < 3; b++) p_beat(b == 2);
    chk("p0_latency", p_out_valid, 1);
    chk("p0_acc", p_acc, {9'd192, 9'd192});
    chk("p0_bin", p_bin, 2'b10);
    chk("p0_beats", p_beats, 3);
    chk("p0_err", p_err, 0);
    @(posedge clk); #1;
    chk("p0_ready_back", p_in_ready, 1);
    for (int b = 0; b < 4; b++) p_beat(1'b0);
    chk("p0_force_valid", p_out_valid, 1);
    chk("p0_force_acc", p_acc, {9'd256, 9'd256});
    chk("p0_force_beats", p_beats, 4);
    chk("p0_force_err", p_err, 1);
    @(posedge clk); #1;
    p_beat(1'b1);
    chk("p0_next_acc", p_acc, {9'd64, 9'd64});
    chk("p0_next_beats", p_beats, 1);
    chk("p0_err_sticky", p_err, 1);
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bnn_pe_array_acc.md
Name: bnn_pe_array_acc

Overview:
- Parametrised successor to the single-beat XNOR-popcount PE array.
- Each of ROWS*COLS PEs accumulates masked XNOR-popcounts over a multi-beat vector of up to MAX_BEATS words, delimited by in_last.
- Emits per-PE accumulated counts plus a binarised activation (acc >= per-PE threshold, i.e. folded batch-norm).
- Valid/ready handshakes on input and output; sits between the weight/activation streamer and the next-layer binariser/writeback.

Parameters:
- ROWS, 8, PE rows
- COLS, 8, PE columns
- WORD_SIZE, 64, bits per beat per PE
- MAX_BEATS, 16, maximum beats per vector before forced termination
- PIPELINE, 1, 1 = register popcount stage; 0 = combinational popcount into accumulator
- Derived: NUM_PES = ROWS*COLS; PCW = $clog2(WORD_SIZE+1); ACC_W = $clog2(MAX_BEATS*WORD_SIZE+1); BCW = $clog2(MAX_BEATS+1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_last  in  1  final beat of current vector
- weights_in_flat  in  NUM_PES*WORD_SIZE  PE i at [i*WORD_SIZE +: WORD_SIZE]
- activations_in_flat  in  NUM_PES*WORD_SIZE  same packing
- valid_mask_flat  in  NUM_PES*WORD_SIZE  1 = bit counted
- thresh_flat  in  NUM_PES*ACC_W  per-PE threshold, sampled at result capture
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  downstream accept
- acc_out_flat  out  NUM_PES*ACC_W  per-PE accumulated count
- bin_out  out  NUM_PES  1 iff acc_out[i] >= thresh[i] (unsigned)
- beats_out  out  BCW  beats in emitted vector (1..MAX_BEATS)
- err_overflow  out  1  sticky: a vector was force-terminated; cleared only by rst

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Per-beat count: pc_i = popcount(~(w_i ^ a_i) & m_i), range 0..WORD_SIZE.
- Reset values: state ACCUM; out_valid 0; acc_out_flat 0; bin_out 0; beats_out 0; err_overflow 0; accumulators 0; beat counter 0; pipeline valid 0.
- A reset during accumulation discards the partial vector. The first beat after reset starts a fresh vector.
- States:
  - ACCUM: in_ready = 1.
  - FLUSH: PIPELINE=1 only; one cycle; in_ready = 0.
  - HOLD: out_valid = 1; in_ready = 0.
- Transitions:
  - ACCUM, accepted beat that is terminal: go to FLUSH if PIPELINE=1, else HOLD.
  - FLUSH always goes to HOLD.
  - HOLD with out_ready goes to ACCUM.
- Terminal beat: in_last = 1, or beat counter == MAX_BEATS-1 (forced).
  - A forced termination without in_last sets err_overflow.
  - in_last on the MAX_BEATS-th beat is legal and does not set err_overflow.
- Accumulate stage, on each (registered if PIPELINE) beat:
  - First beat of a vector: acc_i = pc_i, which clears the prior value.
  - Other beats: acc_i += pc_i.
  - The beat counter increments per accepted beat and clears after a terminal beat.
- Capture: on the terminal beat's accumulate cycle, load acc_out, beats_out and bin_out (using thresh_flat that cycle). out_valid rises the next cycle.
- Latency: terminal beat accepted at cycle t, out_valid at t+1 (PIPELINE=0) or t+2 (PIPELINE=1).
- Outputs stay stable while out_valid & !out_ready.
- out_valid & out_ready: out_valid falls next cycle and in_ready rises the same next cycle. Output data holds its last value.
- Back-to-back beats at full rate inside a vector. Dead cycles between vectors: 1 (PIPELINE=0) or 2 (PIPELINE=1), plus any output stall.
- Width rule: ACC_W cannot overflow, since MAX_BEATS*WORD_SIZE is representable.
- Inputs other than thresh_flat are ignored when no handshake occurs.

Decomposition:
- Package bnn_pkg: state enum (ACCUM, FLUSH, HOLD) and localparam helper functions for PCW, ACC_W, BCW.
- Sub-module bnn_popcount_pe (WORD_SIZE, PCW): combinational masked XNOR-popcount, instantiated NUM_PES times by generate.
- FSM, counters and per-PE accumulators live in the top level.

Test Plan:
- Single beat, PIPELINE=1, PE0 w=64'h589A86C459345B3C, a=64'h6FA49326961A604D, mask all ones, in_last=1 -> out_valid 2 cycles later, PE0 acc=28, beats_out=1; PE63 w=all ones, a=0 -> acc=0.
- 3 beats, all PEs w=a=all ones, full mask, last on beat 3 -> every acc=192, beats_out=3; PIPELINE=0 build gives out_valid 1 cycle after beat 3.
- Mask 64'h0000_0000_FFFF_FFFF, w=a=0, 2 beats -> acc=64; thresh=64 gives bin_out=1, thresh=65 gives bin_out=0.
- out_ready held low 5 cycles with in_valid high -> in_ready=0 throughout, outputs bit-stable; out_ready pulse -> in_ready=1 next cycle, next vector's first beat restarts acc without carrying 192.
- MAX_BEATS=4, 4 all-ones beats with in_last=0 -> forced output acc=256, beats_out=4, err_overflow=1 and stays set across subsequent vectors.
- rst asserted after 2 of 3 beats -> all outputs 0; new 1-beat all-ones vector gives acc=64, beats_out=1.
